// File: rtl/mem_responder_if.sv
// Cache/RAM-side bus of the memory responder: request/wait handshakes plus the RAM port.
interface mem_responder_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_responder.sv
// Arbitrates instruction and data requests onto a single-ported RAM and completes
// each one with a one-cycle wait drop; errors and stalls complete with ERRWORD.
module mem_responder #(
   parameter int unsigned TIMEOUT = 64,
   parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
   input logic           CLK,
   input logic           RST,
   mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;
   typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;

   localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_n;
   grant_t        last, last_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ireq, dreq, done, fail;
   ramstate_t     rs;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         last  <= GRANT_I;
         cnt   <= '0;
      end else begin
         state <= state_n;
         last  <= last_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      last_n       = last;
      cnt_n        = cnt;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      bus.dwait    = 1'b1;
      bus.dload    = '0;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.err      = 1'b0;
      ireq         = bus.iREN;
      dreq         = bus.dREN | bus.dWEN;
      rs           = ramstate_t'(bus.ramstate);
      done         = 1'b0;
      fail         = 1'b0;

      // Completion is resolved once; only the serve states act on it.
      case (rs)
         RS_ACCESS: done = 1'b1;
         RS_ERROR: begin
            done = 1'b1;
            fail = 1'b1;
         end
         default: begin
            if (cnt == CNT_LAST) begin
               done = 1'b1;
               fail = 1'b1;
            end
         end
      endcase

      // Reset holds every output idle so an in-flight completion cannot escape.
      if (!RST) begin
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (ireq && dreq)
                  state_n = (last == GRANT_I) ? DSERV : ISERV;
               else if (ireq)
                  state_n = ISERV;
               else if (dreq)
                  state_n = DSERV;
            end
            ISERV: begin
               if (!ireq) begin
                  state_n = IDLE;
               end else begin
                  bus.ramREN  = 1'b1;
                  bus.ramaddr = bus.iaddr;
                  if (done) begin
                     bus.iwait = 1'b0;
                     bus.iload = fail ? ERRWORD : bus.ramload;
                     bus.err   = fail;
                     state_n   = IDLE;
                     last_n    = GRANT_I;
                  end else begin
                     cnt_n = cnt + CW'(1);
                  end
               end
            end
            DSERV: begin
               if (!dreq) begin
                  state_n = IDLE;
               end else begin
                  bus.ramaddr = bus.daddr;
                  if (bus.dWEN) begin
                     bus.ramWEN   = 1'b1;
                     bus.ramstore = bus.dstore;
                  end else begin
                     bus.ramREN = 1'b1;
                  end
                  if (done) begin
                     bus.dwait = 1'b0;
                     if (fail)
                        bus.dload = ERRWORD;
                     else if (!bus.dWEN)
                        bus.dload = bus.ramload;
                     bus.err = fail;
                     state_n = IDLE;
                     last_n  = GRANT_D;
                  end else begin
                     cnt_n = cnt + CW'(1);
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a transaction-level model predicts grant order,
// completion cycle and load values from the arbitration/timeout rules.
module tb_mem_responder;
   localparam int          TIMEOUT = 64;
   localparam logic [31:0] ERRWORD = 32'hBAD1BAD1;

   logic CLK = 1'b0;
   logic RST;
   int   tests  = 0;
   int   failed = 0;
   bit   last_d = 1'b0;

   mem_responder_if bus ();

   mem_responder #(.TIMEOUT(TIMEOUT), .ERRWORD(ERRWORD)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_iwait"}, bus.iwait, 1);
      check({tag, "_dwait"}, bus.dwait, 1);
      check({tag, "_ramREN"}, bus.ramREN, 0);
      check({tag, "_ramWEN"}, bus.ramWEN, 0);
      check({tag, "_ramaddr"}, bus.ramaddr, 0);
      check({tag, "_err"}, bus.err, 0);
      check({tag, "_dload"}, bus.dload, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
      bus.ramload = 0; bus.ramstate = 2'd0;
      @(negedge CLK);
      #1 check_idle("reset");
      check("reset_ramstore", bus.ramstore, 0);
      check("reset_iload", bus.iload, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1 check_idle("post_reset");
      last_d = 1'b0;
   endtask

   // One granted transaction: an IDLE cycle followed by serve cycles up to completion.
   task automatic txn(input bit wi, input bit wdr, input bit wdw, input int busy,
                      input logic [1:0] fin, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl);
      bit          wd, gd, ferr, fin_c;
      int          done_c;
      logic [31:0] eload;
      wd = wdr | wdw;
      gd = (wi && wd) ? !last_d : wd;
      if (busy + 1 <= TIMEOUT) begin
         done_c = busy + 1;
         ferr   = (fin == 2'd3);
      end else begin
         done_c = TIMEOUT;
         ferr   = 1'b1;
      end
      @(negedge CLK);
      bus.iREN = wi; bus.iaddr = ia;
      bus.dREN = wdr; bus.dWEN = wdw; bus.daddr = da; bus.dstore = ds;
      bus.ramload = rl;
      bus.ramstate = 2'($urandom_range(0, 3));
      #1 check_idle("idle");
      for (int c = 1; c <= done_c; c++) begin
         @(negedge CLK);
         bus.ramstate = (c <= busy) ? 2'($urandom_range(0, 1)) : fin;
         #1;
         fin_c = (c == done_c);
         check("ramREN", bus.ramREN, (gd && wdw) ? 0 : 1);
         check("ramWEN", bus.ramWEN, (gd && wdw) ? 1 : 0);
         check("ramaddr", bus.ramaddr, gd ? da : ia);
         check("ramstore", bus.ramstore, (gd && wdw) ? ds : 0);
         check("iwait", bus.iwait, (fin_c && !gd) ? 0 : 1);
         check("dwait", bus.dwait, (fin_c && gd) ? 0 : 1);
         check("err", bus.err, (fin_c && ferr) ? 1 : 0);
         eload = ferr ? ERRWORD : ((gd && wdw) ? 32'd0 : rl);
         if (fin_c && !gd) check("iload", bus.iload, eload);
         check("dload", bus.dload, (fin_c && gd) ? eload : 32'd0);
      end
      last_d = gd;
   endtask

   initial begin
      int unsigned r, k, busy;
      bit          wi, wdr, wdw;
      logic [1:0]  fin;
      RST = 1'b1;
      do_reset();

      // Lone instruction fetch
      txn(1, 0, 0, 3, 2'd2, 32'h40, 32'h0, 32'h0, 32'h8C220004);

      // Fairness from reset: D first, then alternating with both held
      do_reset();
      for (int n = 0; n < 4; n++)
         txn(1, 0, 1, $urandom_range(0, 4), 2'd2, 32'h80 + n, 32'h200 + n, $urandom, $urandom);

      // Read and write together: write wins
      txn(0, 1, 1, 1, 2'd2, 32'h0, 32'h100, 32'h1234, 32'hFFFF0000);

      // Error completion and timeout
      txn(1, 0, 0, 0, 2'd3, 32'h44, 32'h0, 32'h0, 32'h11111111);
      txn(1, 0, 0, 500, 2'd2, 32'h48, 32'h0, 32'h0, 32'h22222222);
      txn(0, 1, 0, TIMEOUT - 1, 2'd2, 32'h0, 32'h300, 32'h0, 32'h33333333);

      // Data withdrawal before ACCESS
      @(negedge CLK);
      bus.iREN = 0; bus.dREN = 1; bus.dWEN = 0; bus.daddr = 32'h500; bus.ramstate = 2'd1;
      #1 check_idle("wd_idle");
      @(negedge CLK);
      #1 check("wd_serve_ramREN", bus.ramREN, 1);
      @(negedge CLK);
      bus.dREN = 0; bus.ramstate = 2'd2;
      #1 check_idle("wd_drop");
      @(negedge CLK);
      #1 check_idle("wd_after");

      // Reset mid-ISERV
      @(negedge CLK);
      bus.iREN = 1; bus.iaddr = 32'h600; bus.ramload = 32'hCAFEF00D; bus.ramstate = 2'd1;
      #1 check_idle("rst_idle");
      @(negedge CLK);
      #1 check("rst_serve_ramREN", bus.ramREN, 1);
      @(negedge CLK);
      RST = 1'b1; bus.ramstate = 2'd2;
      #1 check_idle("rst_abort");
      @(negedge CLK);
      RST = 1'b0;
      #1 check_idle("rst_next_idle");
      last_d = 1'b0;
      @(negedge CLK);
      #1 check("rst_regrant_iwait", bus.iwait, 0);
      check("rst_regrant_iload", bus.iload, 32'hCAFEF00D);
      @(negedge CLK);
      bus.iREN = 0;

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         r   = $urandom_range(1, 3);
         wi  = r[0];
         wdr = 0;
         wdw = 0;
         if (r[1]) begin
            k   = $urandom_range(1, 3);
            wdr = k[0];
            wdw = k[1];
         end
         busy = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 6);
         fin  = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd2;
         txn(wi, wdr, wdw, int'(busy), fin, $urandom, $urandom, $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
